apb_gpio_debounce: RTL and testbench

// - Per-pin input glitch filter between the GPIO pads and apb_gpio.gpio_in; own APB slave for configuration.
// - Synchronises raw pad inputs and, per enabled pin, propagates a new level only after it has been stable for THRESH prescaled ticks.
// - Disabled pins pass through the synchroniser plus one register.

---
 rtl/apb_gpio_debounce_pkg.sv | 13 +
 rtl/apb_gpio_debounce_if.sv | 23 ++
 rtl/apb_gpio_debounce_cell.sv | 49 ++++
 rtl/apb_gpio_debounce.sv | 112 +++++++++++
 tb/tb_apb_gpio_debounce.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_gpio_debounce_pkg.sv
// Shared constants for the GPIO input debounce block: register word offsets and reset values.
package gpio_debounce_pkg;

    // Word offsets, decoded from PADDR[4:2]
    localparam logic [2:0] REG_DBEN   = 3'd0;
    localparam logic [2:0] REG_PRESC  = 3'd1;
    localparam logic [2:0] REG_THRESH = 3'd2;
    localparam logic [2:0] REG_RAW    = 3'd3;
    localparam logic [2:0] REG_FILT   = 3'd4;

    localparam int unsigned THRESH_RESET = 4;

endpackage

// File: rtl/apb_gpio_debounce_if.sv
// APB3 configuration port of the debounce block; master drives requests, slave answers.
interface apb_gpio_debounce_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_gpio_debounce_cell.sv
// One pin of the debounce filter: stability counter plus the filtered output bit.
module gpio_debounce_cell #(
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 tick,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] thresh_eff,
    input  logic                 din,
    output logic                 dout
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 dout_q, dout_d;

    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (!en) begin
            dout_d = din;
            cnt_d  = '0;
        end else if (din == dout_q || clr) begin
            // A config write restarts filtering but never moves the output
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q >= thresh_eff - CNT_WIDTH'(1)) begin
                dout_d = din;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/apb_gpio_debounce.sv
// Per-pin glitch filter for GPIO pad inputs with an APB slave for enable/prescaler/threshold.
module apb_gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned NUM_GPIO       = 32,
    parameter int unsigned PRESC_WIDTH    = 16,
    parameter int unsigned CNT_WIDTH      = 4
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    apb_gpio_debounce_if.slave  apb,
    input  logic [NUM_GPIO-1:0] pad_in,
    output logic [NUM_GPIO-1:0] gpio_filt
);

    logic [NUM_GPIO-1:0]    dben_q, dben_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [CNT_WIDTH-1:0]   thresh_q, thresh_d;
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [NUM_GPIO-1:0]    sync0_q, sync1_q;
    logic [CNT_WIDTH-1:0]   thresh_eff;
    logic [2:0]             reg_sel;
    logic                   wr_en;
    logic                   cfg_wr;
    logic                   tick;
    logic [31:0]            prdata;
    logic                   unused_bus_bits;

    assign reg_sel = apb.PADDR[4:2];
    assign wr_en   = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign cfg_wr  = wr_en & ((reg_sel == REG_DBEN) | (reg_sel == REG_PRESC) |
                              (reg_sel == REG_THRESH));

    // Only PADDR[4:2] and the low PWDATA bits are decoded
    assign unused_bus_bits = ^{apb.PADDR, apb.PWDATA};

    assign thresh_eff = (thresh_q == '0) ? CNT_WIDTH'(1) : thresh_q;
    assign tick       = (presc_cnt_q == presc_q);

    always_comb begin
        dben_d   = dben_q;
        presc_d  = presc_q;
        thresh_d = thresh_q;
        if (wr_en) begin
            case (reg_sel)
                REG_DBEN:   dben_d   = apb.PWDATA[NUM_GPIO-1:0];
                REG_PRESC:  presc_d  = apb.PWDATA[PRESC_WIDTH-1:0];
                REG_THRESH: thresh_d = apb.PWDATA[CNT_WIDTH-1:0];
                default:    ;
            endcase
        end
    end

    always_comb begin
        if (cfg_wr || tick) begin
            presc_cnt_d = '0;
        end else begin
            presc_cnt_d = presc_cnt_q + PRESC_WIDTH'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dben_q      <= '0;
            presc_q     <= '0;
            thresh_q    <= CNT_WIDTH'(THRESH_RESET);
            presc_cnt_q <= '0;
            sync0_q     <= '0;
            sync1_q     <= '0;
        end else begin
            dben_q      <= dben_d;
            presc_q     <= presc_d;
            thresh_q    <= thresh_d;
            presc_cnt_q <= presc_cnt_d;
            sync0_q     <= pad_in;
            sync1_q     <= sync0_q;
        end
    end

    always_comb begin
        prdata = '0;
        case (reg_sel)
            REG_DBEN:   prdata[NUM_GPIO-1:0]    = dben_q;
            REG_PRESC:  prdata[PRESC_WIDTH-1:0] = presc_q;
            REG_THRESH: prdata[CNT_WIDTH-1:0]   = thresh_q;
            REG_RAW:    prdata[NUM_GPIO-1:0]    = sync1_q;
            REG_FILT:   prdata[NUM_GPIO-1:0]    = gpio_filt;
            default:    ;
        endcase
    end

    assign apb.PRDATA  = prdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_cell
        gpio_debounce_cell #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cell (
            .clk        (HCLK),
            .rstn       (HRESETn),
            .en         (dben_q[g]),
            .tick       (tick),
            .clr        (cfg_wr),
            .thresh_eff (thresh_eff),
            .din        (sync1_q[g]),
            .dout       (gpio_filt[g])
        );
    end

endmodule

// File: tb/tb_apb_gpio_debounce.sv
// Directed and randomized bench for apb_gpio_debounce against a cycle-level behavioural model.
module tb_apb_gpio_debounce;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] pad_in;
    logic [31:0] gpio_filt;

    apb_gpio_debounce_if #(.APB_ADDR_WIDTH(12)) apb ();

    apb_gpio_debounce #(
        .APB_ADDR_WIDTH (12),
        .NUM_GPIO       (32),
        .PRESC_WIDTH    (16),
        .CNT_WIDTH      (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .apb       (apb),
        .pad_in    (pad_in),
        .gpio_filt (gpio_filt)
    );

    always #5 HCLK = ~HCLK;

    // Reference model state: pipeline of pad samples, registers, edges since the
    // last prescaler restart, and per-pin count of ticks a mismatch has persisted.
    logic [31:0] m_sync0, m_sync1, m_filt, m_dben;
    logic [15:0] m_presc;
    logic [3:0]  m_thresh;
    int          m_elapsed;
    int          m_run [32];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_sync0   = '0;
        m_sync1   = '0;
        m_filt    = '0;
        m_dben    = '0;
        m_presc   = '0;
        m_thresh  = 4'd4;
        m_elapsed = 0;
        for (int i = 0; i < 32; i++) m_run[i] = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] sel);
        case (sel)
            3'd0:    return m_dben;
            3'd1:    return {16'h0, m_presc};
            3'd2:    return {28'h0, m_thresh};
            3'd3:    return m_sync1;
            3'd4:    return m_filt;
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock: model next state from pre-edge inputs, then compare after the edge
    task automatic cycle();
        logic [31:0] n_filt, p, wd;
        logic [2:0]  sel;
        bit          wr, cfg, tick;
        int          teff;
        sel  = apb.PADDR[4:2];
        wr   = apb.PSEL && apb.PENABLE && apb.PWRITE;
        cfg  = wr && (sel <= 3'd2);
        wd   = apb.PWDATA;
        p    = pad_in;
        tick = (m_elapsed % (int'(m_presc) + 1)) == int'(m_presc);
        teff = (m_thresh == 0) ? 1 : int'(m_thresh);
        n_filt = m_filt;
        for (int i = 0; i < 32; i++) begin
            if (!m_dben[i]) begin
                n_filt[i] = m_sync1[i];
                m_run[i]  = 0;
            end else if (m_sync1[i] == m_filt[i] || cfg) begin
                m_run[i] = 0;
            end else if (tick) begin
                m_run[i]++;
                if (m_run[i] >= teff) begin
                    n_filt[i] = m_sync1[i];
                    m_run[i]  = 0;
                end
            end
        end
        @(posedge HCLK);
        m_filt    = n_filt;
        m_sync1   = m_sync0;
        m_sync0   = p;
        m_elapsed = cfg ? 0 : m_elapsed + 1;
        if (wr && sel == 3'd0) m_dben = wd;
        if (wr && sel == 3'd1) m_presc = wd[15:0];
        if (wr && sel == 3'd2) m_thresh = wd[3:0];
        #1;
        check("filt_vs_model", gpio_filt, m_filt);
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = addr;
        apb.PWDATA  = data;
        cycle();
        apb.PENABLE = 1'b1;
        cycle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] addr, input string tag, output logic [31:0] rd);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = addr;
        cycle();
        apb.PENABLE = 1'b1;
        #1;
        rd = apb.PRDATA;
        check(tag, rd, model_read(addr[4:2]));
        check("pready", {31'h0, apb.PREADY}, 32'h1);
        check("pslverr", {31'h0, apb.PSLVERR}, 32'h0);
        cycle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
    endtask

    task automatic edges_until(input int pin, input logic val, input int max, output int edges);
        edges = -1;
        for (int k = 1; k <= max; k++) begin
            cycle();
            if (gpio_filt[pin] === val) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int          e;
        bit          seen;

        HRESETn     = 1'b0;
        pad_in      = '0;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        model_reset();
        #2;
        check("reset_filt", gpio_filt, 32'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Reset register values
        apb_read(12'h000, "rst_dben", rd);
        check("rst_dben_const", rd, 32'h0);
        apb_read(12'h004, "rst_presc", rd);
        check("rst_presc_const", rd, 32'h0);
        apb_read(12'h008, "rst_thresh", rd);
        check("rst_thresh_const", rd, 32'h4);
        apb_read(12'h010, "rst_filt_reg", rd);
        check("rst_filt_const", rd, 32'h0);
        apb_read(12'h00C, "rst_raw", rd);
        apb_read(12'h014, "unmapped_0x14", rd);
        check("unmapped_const", rd, 32'h0);

        // Bypass: three edges from pad to output
        pad_in = 32'hA5A5_0F0F;
        cycle();
        cycle();
        check("bypass_2_edges", gpio_filt, 32'h0);
        cycle();
        check("bypass_3_edges", gpio_filt, 32'hA5A5_0F0F);
        apb_read(12'h010, "bypass_filt_reg", rd);
        apb_read(12'h00C, "bypass_raw_reg", rd);
        pad_in = '0;
        repeat (3) cycle();

        // Filter: PRESC=0, THRESH=4
        apb_write(12'h000, 32'hFFFF_FFFF);
        apb_write(12'h004, 32'h0);
        apb_write(12'h008, 32'h4);
        pad_in[0] = 1'b1;
        edges_until(0, 1'b1, 20, e);
        check("filter_latency_pin0", e, 32'd6);
        seen = 1'b0;
        pad_in[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) pad_in[1] = 1'b0;
            cycle();
            seen |= gpio_filt[1];
        end
        check("glitch_3cyc_pin1", {31'h0, seen}, 32'h0);

        // Prescaler: PRESC=9, THRESH=2
        apb_write(12'h004, 32'd9);
        apb_write(12'h008, 32'd2);
        pad_in[5] = 1'b1;
        edges_until(5, 1'b1, 40, e);
        check("presc_lat_in_range", {31'h0, (e - 2 >= 11) && (e - 2 <= 20)}, 32'h1);
        apb_write(12'h004, 32'd9);
        seen = 1'b0;
        pad_in[5] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 15) pad_in[5] = 1'b1;
            cycle();
            seen |= ~gpio_filt[5];
        end
        check("glitch_15cyc_pin5", {31'h0, seen}, 32'h0);

        // THRESH=0 acts as 1: single-cycle pulse passes with 3-edge latency
        apb_write(12'h004, 32'h0);
        apb_write(12'h008, 32'h0);
        apb_read(12'h008, "thresh_zero_reg", rd);
        e = -1;
        pad_in[7] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            if (k == 1) pad_in[7] = 1'b0;
            if (gpio_filt[7] === 1'b1) begin
                e = k;
                break;
            end
        end
        check("thresh0_latency_pin7", e, 32'd3);
        cycle();
        check("thresh0_pulse_ends", {31'h0, gpio_filt[7]}, 32'h0);

        // Config write mid-count restarts the count
        apb_write(12'h008, 32'h4);
        apb_write(12'h004, 32'h3);
        pad_in[9] = 1'b1;
        repeat (12) cycle();
        check("midcount_held", {31'h0, gpio_filt[9]}, 32'h0);
        apb_write(12'h004, 32'h3);
        edges_until(9, 1'b1, 40, e);
        check("midcount_after_write", e, 32'd16);

        // Reset mid-count clears everything at once
        pad_in[11] = 1'b1;
        repeat (6) cycle();
        HRESETn = 1'b0;
        #1;
        check("reset_mid_filt", gpio_filt, 32'h0);
        model_reset();
        #1;
        HRESETn = 1'b1;
        apb_read(12'h000, "post_rst_dben", rd);
        apb_read(12'h008, "post_rst_thresh", rd);
        check("post_rst_thresh_const", rd, 32'h4);

        // Randomized configurations and pad activity
        for (int seg = 0; seg < 6; seg++) begin
            apb_write(12'h000, $urandom);
            apb_write(12'h004, $urandom_range(0, 3));
            apb_write(12'h008, $urandom_range(0, 6));
            for (int k = 0; k < 80; k++) begin
                pad_in ^= ($urandom & $urandom & $urandom);
                cycle();
                if (k % 25 == 24) begin
                    apb_read(12'h010, "rand_filt_reg", rd);
                    apb_read(12'h00C, "rand_raw_reg", rd);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
